tlul_master: RTL and testbench
==============================

Name: tlul_master

Overview:
- Single-outstanding TileLink-UL initiator. Converts a simple command/response interface from a local controller into Channel-A requests, and Channel-D responses back into a response.
- Pairs with the 24 MHz memory-mapped TL-UL slave on the same clk_24 domain.
- Adds response-error classification and a D-channel timeout so a dead responder cannot hang the controller.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
MASK_WIDTH, DATA_WIDTH/8, byte-mask width
SIZE_WIDTH, 3, size field width (log2 bytes)
OPCODE_WIDTH, 3, opcode width
TIMEOUT_WIDTH, 8, timeout counter width; timeout fires after 2**TIMEOUT_WIDTH-1 cycles in S_WAIT

Ports:
clk_24  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_mask  in  MASK_WIDTH  byte enables
cmd_size  in  SIZE_WIDTH  transfer size
a_valid  out  1  A-channel valid
a_ready  in  1  A-channel ready
a_opcode  out  OPCODE_WIDTH  Get=0, PutFullData=1, PutPartialData=2
a_size  out  SIZE_WIDTH  size
a_address  out  ADDR_WIDTH  address
a_mask  out  MASK_WIDTH  mask
a_data  out  DATA_WIDTH  write data
d_valid  in  1  D-channel valid
d_ready  out  1  D-channel ready
d_opcode  in  OPCODE_WIDTH  AccessAck=3, AccessAckData=4
d_size  in  SIZE_WIDTH  response size
d_denied  in  1  responder denied
d_data  in  DATA_WIDTH  read data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
rsp_err  out  1  denied, opcode mismatch, or timeout
rsp_timeout  out  1  error cause was timeout
busy  out  1  state != S_IDLE
stale_drop  out  1  one-cycle pulse: D beat discarded outside S_WAIT

Behaviour:
- Reset (async, rst_n low): state=S_IDLE.
- Reset values: all a_* outputs, rsp_* outputs, busy, stale_drop and timeout counter = 0; d_ready=1; cmd_ready=1.
- States: S_IDLE, S_REQ, S_WAIT, S_DONE, all registered.
- S_IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the command into A registers; a_valid=1 next cycle; go S_REQ.
  - Opcode selection: read -> Get; write with mask all ones -> PutFullData; otherwise PutPartialData.
  - For Get, a_data=0 and a_mask=cmd_mask.
- S_REQ:
  - a_valid=1; all a_* held stable until a_ready.
  - On a_valid&&a_ready, go S_WAIT with a_valid=0 next cycle.
  - d_ready=0 in this state only.
- S_WAIT:
  - d_ready=1; the timeout counter increments each cycle, starting from 0.
  - On d_valid:
    - Capture the response; go S_DONE.
    - rsp_err = d_denied, or d_opcode differs from the expected value (Get expects AccessAckData, Put expects AccessAck).
    - rsp_rdata = d_data only for a good AccessAckData; otherwise 0.
    - rsp_timeout=0.
  - If the counter reaches all ones with no d_valid: go S_DONE with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - d_valid in the same cycle the counter saturates: the response wins, no timeout.
- S_DONE:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On handshake: rsp_valid=0 next cycle; go S_IDLE.
  - cmd_ready=0, so a new command is not accepted in the same cycle.
- Stale beats: a d_valid seen in S_IDLE or S_DONE is accepted (d_ready=1) and discarded; stale_drop pulses for one cycle. This covers late responses after a timeout.
- Minimum latency (a_ready=1, slave responds one cycle after A handshake, rsp_ready=1):
  - cmd accept at edge 0; a_valid high cycle 1; d_valid cycle 2; rsp_valid cycle 3; idle cycle 4.
- busy=1 in all states except S_IDLE. Only one transaction is ever outstanding.
- Reset asserted mid-transaction aborts immediately to reset values; no response is produced.

Test Plan:
- Write 0x4000_0010 data 0xCAFE_F00D mask 0xF, slave always-ready -> a_opcode=1, a_address=0x4000_0010; d_opcode=3 returns; rsp_valid in cycle 3 with rsp_err=0, rsp_rdata=0.
- Read back 0x4000_0010 -> a_opcode=0; rsp_rdata=0xCAFE_F00D, rsp_err=0.
- Write mask 0x3 -> a_opcode=2, a_mask=0x3. Read 0x3FFF_FFFC with d_denied=1 -> rsp_err=1, rsp_rdata=0.
- Hold a_ready=0 for 5 cycles -> a_valid and all a_* stable for 6 cycles; exactly one A handshake. Hold rsp_ready=0 for 4 cycles -> rsp_* stable and cmd_ready=0.
- No d_valid after A handshake -> rsp_timeout=1, rsp_err=1 exactly 255 cycles after entering S_WAIT. A late d_valid in S_IDLE -> stale_drop pulses once, no rsp_valid.
- Drive rst_n low while in S_WAIT -> a_valid=0, rsp_valid=0, busy=0 immediately. After release, the next command completes normally.

Source files
------------

// File: rtl/tlul_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tlul_master: single-outstanding TL-UL initiator with D-channel timeout.     |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+

module tlul_master #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MASK_WIDTH    = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH    = 3,
  parameter int OPCODE_WIDTH  = 3,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                    clk_24,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [MASK_WIDTH-1:0]   cmd_mask,
  input  logic [SIZE_WIDTH-1:0]   cmd_size,
  output logic                    a_valid,
  input  logic                    a_ready,
  output logic [OPCODE_WIDTH-1:0] a_opcode,
  output logic [SIZE_WIDTH-1:0]   a_size,
  output logic [ADDR_WIDTH-1:0]   a_address,
  output logic [MASK_WIDTH-1:0]   a_mask,
  output logic [DATA_WIDTH-1:0]   a_data,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [OPCODE_WIDTH-1:0] d_opcode,
  input  logic [SIZE_WIDTH-1:0]   d_size,
  input  logic                    d_denied,
  input  logic [DATA_WIDTH-1:0]   d_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic                    stale_drop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_GET          = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL     = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PARTIAL  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK          = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA     = OPCODE_WIDTH'(4);
  // Counter value in the last waiting cycle; the register reaches all ones as we leave.
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'((2 ** TIMEOUT_WIDTH) - 2);

  state_e                  state_q, state_d;
  logic                    a_valid_q, a_valid_d;
  logic [OPCODE_WIDTH-1:0] a_opcode_q, a_opcode_d;
  logic [SIZE_WIDTH-1:0]   a_size_q, a_size_d;
  logic [ADDR_WIDTH-1:0]   a_address_q, a_address_d;
  logic [MASK_WIDTH-1:0]   a_mask_q, a_mask_d;
  logic [DATA_WIDTH-1:0]   a_data_q, a_data_d;
  logic                    exp_data_q, exp_data_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    stale_drop_q, stale_drop_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  logic [OPCODE_WIDTH-1:0] exp_opcode;
  logic                    d_bad;
  logic                    unused_d_size;

  assign unused_d_size = ^d_size;
  assign exp_opcode    = exp_data_q ? OP_ACK_DATA : OP_ACK;
  assign d_bad         = d_denied | (d_opcode != exp_opcode);

  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      a_valid_q     <= 1'b0;
      a_opcode_q    <= '0;
      a_size_q      <= '0;
      a_address_q   <= '0;
      a_mask_q      <= '0;
      a_data_q      <= '0;
      exp_data_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      stale_drop_q  <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      a_valid_q     <= a_valid_d;
      a_opcode_q    <= a_opcode_d;
      a_size_q      <= a_size_d;
      a_address_q   <= a_address_d;
      a_mask_q      <= a_mask_d;
      a_data_q      <= a_data_d;
      exp_data_q    <= exp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      stale_drop_q  <= stale_drop_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    a_valid_d     = a_valid_q;
    a_opcode_d    = a_opcode_q;
    a_size_d      = a_size_q;
    a_address_d   = a_address_q;
    a_mask_d      = a_mask_q;
    a_data_d      = a_data_q;
    exp_data_d    = exp_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    stale_drop_d  = 1'b0;
    cnt_d         = '0;

    case (state_q)
      S_IDLE: begin
        stale_drop_d = d_valid;
        if (cmd_valid) begin
          a_valid_d   = 1'b1;
          a_size_d    = cmd_size;
          a_address_d = cmd_addr;
          a_mask_d    = cmd_mask;
          exp_data_d  = ~cmd_write;
          if (!cmd_write) begin
            a_opcode_d = OP_GET;
            a_data_d   = '0;
          end else begin
            a_opcode_d = (&cmd_mask) ? OP_PUT_FULL : OP_PUT_PARTIAL;
            a_data_d   = cmd_wdata;
          end
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (a_ready) begin
          a_valid_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response arriving in the final cycle takes priority over the timeout.
        if (d_valid) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = d_bad;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (exp_data_q && !d_bad) ? d_data : '0;
          state_d       = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        stale_drop_d = d_valid;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign d_ready     = (state_q != S_REQ);
  assign busy        = (state_q != S_IDLE);
  assign a_valid     = a_valid_q;
  assign a_opcode    = a_opcode_q;
  assign a_size      = a_size_q;
  assign a_address   = a_address_q;
  assign a_mask      = a_mask_q;
  assign a_data      = a_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign stale_drop  = stale_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_tlul_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tlul_master: directed scoreboard bench for the TL-UL initiator.          |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+

module tb_tlul_master;

  localparam int HALF = 20;

  logic        clk_24 = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_mask;
  logic [2:0]  cmd_size;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_size;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        d_valid, d_ready, d_denied;
  logic [2:0]  d_opcode, d_size;
  logic [31:0] d_data;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy, stale_drop;
  logic [31:0] rsp_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [logic [31:0]];
  int          errors = 0;
  int          checks = 0;
  int          hs_cnt = 0;

  always #HALF clk_24 = ~clk_24;

  always @(posedge clk_24) if (a_valid && a_ready) hs_cnt <= hs_cnt + 1;

  tlul_master dut (
    .clk_24(clk_24), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask), .cmd_size(cmd_size),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_denied(d_denied), .d_data(d_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy), .stale_drop(stale_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data, input logic [2:0] size);
    chk({tag, "_a_valid"}, 64'(a_valid), 64'd1);
    chk({tag, "_a_opcode"}, 64'(a_opcode), 64'(op));
    chk({tag, "_a_address"}, 64'(a_address), 64'(addr));
    chk({tag, "_a_mask"}, 64'(a_mask), 64'(mask));
    chk({tag, "_a_data"}, 64'(a_data), 64'(data));
    chk({tag, "_a_size"}, 64'(a_size), 64'(size));
    chk({tag, "_d_ready_req"}, 64'(d_ready), 64'd0);
  endtask

  // One complete command; to_mode leaves the D channel silent to force a timeout.
  task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] mask, input logic [2:0] size,
                     input int a_stall, input int rsp_stall, input logic [2:0] dop,
                     input logic den, input bit to_mode, input logic [2:0] exp_aop);
    exp_t        e, got;
    logic [31:0] ddata;
    int          hs0, n;
    @(negedge clk_24);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    ddata = wr ? 32'hDEAD_BEEF : (mem.exists(addr) ? mem[addr] : (32'h0BAD_0000 ^ addr));
    if (to_mode) e = '{rdata: 32'h0, err: 1'b1, tmo: 1'b1};
    else begin
      e.err   = den || (dop != (wr ? 3'd3 : 3'd4));
      e.rdata = (!wr && !e.err) ? ddata : 32'h0;
      e.tmo   = 1'b0;
      if (wr && !e.err) begin
        logic [31:0] old;
        old = mem.exists(addr) ? mem[addr] : 32'h0;
        for (int b = 0; b < 4; b++) if (mask[b]) old[b*8 +: 8] = wdata[b*8 +: 8];
        mem[addr] = old;
      end
    end
    sb_q.push_back(e);
    hs0 = hs_cnt;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    cmd_mask = mask; cmd_size = size;
    @(negedge clk_24);
    cmd_valid = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk_a(tag, exp_aop, addr, mask, wr ? wdata : 32'h0, size);
    for (int i = 0; i < a_stall; i++) begin
      a_ready = 1'b0;
      @(negedge clk_24);
      chk_a({tag, "_stall"}, exp_aop, addr, mask, wr ? wdata : 32'h0, size);
    end
    a_ready = 1'b1;
    @(negedge clk_24);
    a_ready = 1'b0;
    chk({tag, "_a_valid_drop"}, 64'(a_valid), 64'd0);
    chk({tag, "_d_ready_wait"}, 64'(d_ready), 64'd1);
    if (to_mode) begin
      n = 0;
      while (!rsp_valid && n < 400) begin
        @(negedge clk_24);
        n++;
      end
      chk({tag, "_timeout_cycles"}, 64'(n), 64'd255);
    end else begin
      d_valid = 1'b1; d_opcode = dop; d_denied = den; d_data = ddata; d_size = size;
      @(negedge clk_24);
      d_valid = 1'b0; d_denied = 1'b0;
    end
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    else begin
      got = sb_q.pop_front();
      for (int i = 0; i <= rsp_stall; i++) begin
        rsp_ready = (i == rsp_stall);
        chk({tag, "_rsp_valid_hold"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(got.rdata));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(got.err));
        chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'(got.tmo));
        chk({tag, "_cmd_ready_done"}, 64'(cmd_ready), 64'd0);
        @(negedge clk_24);
      end
    end
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_clear"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_busy_clear"}, 64'(busy), 64'd0);
    chk({tag, "_a_handshakes"}, 64'(hs_cnt - hs0), 64'd1);
  endtask

  initial begin
    #(HALF * 2 * 5000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_mask = '0; cmd_size = '0; a_ready = 1'b0; d_valid = 1'b0; d_opcode = '0;
    d_size = '0; d_denied = 1'b0; d_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk_24);
    chk("rst_a_valid", 64'(a_valid), 64'd0);
    chk("rst_a_fields", 64'({a_opcode, a_size, a_mask}), 64'd0);
    chk("rst_a_address", 64'(a_address), 64'd0);
    chk("rst_a_data", 64'(a_data), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_busy_stale", 64'({busy, stale_drop}), 64'd0);
    chk("rst_ready", 64'({d_ready, cmd_ready}), 64'd3);
    rst_n = 1'b1;

    txn("wr_full",   1'b1, 32'h4000_0010, 32'hCAFE_F00D, 4'hF, 3'd2, 0, 0, 3'd3, 1'b0, 1'b0, 3'd1);
    txn("rd_back",   1'b0, 32'h4000_0010, 32'h0,         4'hF, 3'd2, 0, 0, 3'd4, 1'b0, 1'b0, 3'd0);
    txn("wr_part",   1'b1, 32'h4000_0020, 32'h1122_3344, 4'h3, 3'd1, 0, 0, 3'd3, 1'b0, 1'b0, 3'd2);
    txn("rd_denied", 1'b0, 32'h3FFF_FFFC, 32'h0,         4'hF, 3'd2, 0, 0, 3'd4, 1'b1, 1'b0, 3'd0);
    txn("wr_stall",  1'b1, 32'h4000_0030, 32'hA5A5_5A5A, 4'hF, 3'd2, 5, 4, 3'd3, 1'b0, 1'b0, 3'd1);
    txn("wr_badop",  1'b1, 32'h4000_0040, 32'h0F0F_0F0F, 4'hC, 3'd2, 0, 0, 3'd4, 1'b0, 1'b0, 3'd2);
    txn("rd_badop",  1'b0, 32'h4000_0030, 32'h0,         4'hF, 3'd2, 0, 1, 3'd3, 1'b0, 1'b0, 3'd0);
    txn("rd_tmo",    1'b0, 32'h4000_0010, 32'h0,         4'hF, 3'd2, 0, 0, 3'd4, 1'b0, 1'b1, 3'd0);

    // Late response arriving after the timeout, while idle.
    d_valid = 1'b1; d_opcode = 3'd4; d_data = 32'h1234_5678;
    chk("stale_d_ready", 64'(d_ready), 64'd1);
    @(negedge clk_24);
    d_valid = 1'b0;
    chk("stale_pulse", 64'(stale_drop), 64'd1);
    chk("stale_no_rsp", 64'(rsp_valid), 64'd0);
    @(negedge clk_24);
    chk("stale_pulse_end", 64'(stale_drop), 64'd0);
    chk("stale_idle", 64'(busy), 64'd0);

    // Abort a read in the wait state with reset.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0010; cmd_mask = 4'hF;
    @(negedge clk_24);
    cmd_valid = 1'b0; a_ready = 1'b1;
    @(negedge clk_24);
    a_ready = 1'b0;
    repeat (3) @(negedge clk_24);
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_a_valid", 64'(a_valid), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk_24);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_24);
    chk("abort_no_rsp", 64'(rsp_valid), 64'd0);

    txn("rd_after_rst", 1'b0, 32'h4000_0010, 32'h0, 4'hF, 3'd2, 0, 0, 3'd4, 1'b0, 1'b0, 3'd0);
    txn("rd_partial",   1'b0, 32'h4000_0020, 32'h0, 4'h3, 3'd1, 1, 0, 3'd4, 1'b0, 1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
